sram_banked_burst: RTL
======================

# sram_banked_burst

Parametrised banked SRAM for the LSTM weight and state buffers, built from BANK_W-wide banks concatenated into one DATA_W-wide word. It adds per-bank write masking and a burst read engine that streams LEN consecutive rows with a consumer back-pressure handshake. It sits between the weight loader (write side) and the LSTM gate datapath (read side).

## Interface
- DATA_W, 4096, full word width; must be a multiple of BANK_W
- BANK_W, 128, width of one bank; NBANK = DATA_W/BANK_W (default 32)
- DEPTH, 256, rows per bank; power of two
- ADDR_W, 8, log2(DEPTH)
- LEN_W, 5, burst length field width; legal lengths 1..2^LEN_W-1
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  asynchronous active-low reset
- iW_en  in  1  write strobe
- iW_addr  in  ADDR_W  write row
- iW_mask  in  NBANK  per-bank write enable; bit b covers iD_in[(NBANK-b)*BANK_W-1 -: BANK_W], so bank 0 is the MSB slice
- iD_in  in  DATA_W  write data
- iR_start  in  1  burst request
- iR_addr  in  ADDR_W  burst start row
- iR_len  in  LEN_W  burst length in rows
- iD_ready  in  1  consumer accepts the current beat
- oR_busy  out  1  burst in progress
- oD_valid  out  1  oD_out holds a beat
- oD_out  out  DATA_W  read data, registered
- oR_done  out  1  one-cycle pulse when the last beat is accepted

## Operation
- FSM states:
  - IDLE:
    - At an edge with iR_start=1 and iR_len!=0: latch ptr=iR_addr and cnt=iR_len, then go to BURST.
    - iR_start with iR_len=0 is ignored.
  - BURST:
    - An edge with oD_valid=0, or with oD_valid=1 and iD_ready=1, is an advance edge.
    - If cnt>0 at an advance edge: read row ptr into oD_out, set oD_valid=1, ptr=ptr+1 mod DEPTH, cnt=cnt-1.
    - If cnt==0 at an advance edge (last beat being accepted): clear oD_valid, pulse oR_done, return to IDLE.
    - If oD_valid=1 and iD_ready=0: hold oD_out, oD_valid, ptr and cnt.
- iR_start is ignored while oR_busy=1.
- oR_busy=1 exactly while the FSM is in BURST.
- Writes are independent of the FSM and are accepted every cycle. At an edge with iW_en=1, bank b row iW_addr takes its slice of iD_in only where iW_mask[b]=1.
- iW_en=1 with iW_mask=0 is a no-op.
- Address arithmetic wraps modulo DEPTH: start DEPTH-2 with length 4 reads rows DEPTH-2, DEPTH-1, 0, 1.
- Memory contents are not reset.

## Timing
- Reset values: oR_busy=0, oD_valid=0, oD_out=0, oR_done=0; FSM=IDLE, ptr=0, cnt=0.
- Reset takes effect immediately on rstn falling, including mid-burst. The burst is abandoned with no oR_done.
- Latency: iR_start sampled at edge E0 puts the first beat on oD_out after edge E1, 2 cycles from request.
- With iD_ready held high, one beat per cycle. LEN beats occupy edges E1..E_LEN. oR_done pulses after edge E_LEN+1, and oR_busy falls at the same edge.
- The earliest new iR_start is sampled one edge after oR_busy falls.
- Write to read row in the same edge (iW_en=1, iW_addr==ptr, advance edge): result is governed by the Configuration macro below.
- A write to a row already read or not yet read needs no special handling; the burst returns the array contents at each beat's read edge.

## Configuration
- SRAM_WR_BYPASS_EN:
  - Defined: on a same-edge write/read collision, each masked bank slice of oD_out takes iD_in (write-first). Unmasked slices take old data.
  - Undefined: oD_out takes old array data for all banks (read-first). No bypass mux is synthesised.

## Test plan
- Reset, then write rows 0..3 with full mask, data {row replicated}, then burst addr=0 len=4 with iD_ready=1 -> beats 0,1,2,3 on consecutive cycles. First beat 2 cycles after the request; oR_done pulses once; oR_busy is high for 5 cycles.
- Write row 5 with all-ones data and iW_mask=32'h8000_0001, over a row previously all zeros; burst addr=5 len=1 -> oD_out[4095:3968] and oD_out[127:0] are all ones, the rest is zero.
- Burst addr=254 len=4 with iD_ready toggling 1,0,0,1,... -> rows 254,255,0,1 in order. oD_out is stable while iD_ready=0, and no beat is lost or duplicated.
- During a burst at ptr=10, write row 10 with data A, old data B -> oD_out=A with SRAM_WR_BYPASS_EN defined, B without.
- iR_start with len=0, and iR_start while busy -> ignored: no oR_busy rise, no state change to the active burst.
- Drop rstn mid-burst after beat 2 of 6 -> oD_valid, oR_busy and oD_out go to 0 immediately and no oR_done follows. A new burst after reset behaves as in the first scenario.

Source files
------------

// File: rtl/sram_banked_burst.sv
// Banked SRAM (NBANK x BANK_W) with per-bank write mask and a back-pressured burst reader.
// Optional macro SRAM_WR_BYPASS_EN: write-first forwarding on a same-edge write/read row collision.
module sram_banked_burst #(
  parameter int DATA_W = 4096,
  parameter int BANK_W = 128,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       iW_en,
  input  logic [ADDR_W-1:0]          iW_addr,
  input  logic [DATA_W/BANK_W-1:0]   iW_mask,
  input  logic [DATA_W-1:0]          iD_in,
  input  logic                       iR_start,
  input  logic [ADDR_W-1:0]          iR_addr,
  input  logic [LEN_W-1:0]           iR_len,
  input  logic                       iD_ready,
  output logic                       oR_busy,
  output logic                       oD_valid,
  output logic [DATA_W-1:0]          oD_out,
  output logic                       oR_done
);

  localparam int NBANK = DATA_W / BANK_W;

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] ptr, ptrNext;
  logic [LEN_W-1:0]  cnt, cntNext;
  logic              validNext, doneNext, loadBeat;
  logic [BANK_W-1:0] rdBank [NBANK];
  logic [DATA_W-1:0] rdWord;

  // Bank b owns the b-th slice counted from the MSB end of the word.
  for (genvar b = 0; b < NBANK; b++) begin : gBank
    logic [BANK_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (iW_en && iW_mask[b])
        mem[iW_addr] <= iD_in[(NBANK-b)*BANK_W-1 -: BANK_W];
    end

`ifdef SRAM_WR_BYPASS_EN
    assign rdBank[b] = (iW_en && iW_mask[b] && (iW_addr == ptr))
                       ? iD_in[(NBANK-b)*BANK_W-1 -: BANK_W] : mem[ptr];
`else
    assign rdBank[b] = mem[ptr];
`endif
  end

  always_comb begin
    rdWord = '0;
    for (int unsigned b = 0; b < NBANK; b++)
      rdWord[(NBANK-b)*BANK_W-1 -: BANK_W] = rdBank[b];
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    cntNext   = cnt;
    validNext = oD_valid;
    doneNext  = 1'b0;
    loadBeat  = 1'b0;
    unique case (state)
      IDLE: begin
        if (iR_start && (iR_len != '0)) begin
          stateNext = BURST;
          ptrNext   = iR_addr;
          cntNext   = iR_len;
        end
      end
      BURST: begin
        // Advance whenever the output register is empty or being drained.
        if (!oD_valid || iD_ready) begin
          if (cnt != '0) begin
            loadBeat  = 1'b1;
            validNext = 1'b1;
            ptrNext   = ptr + 1'b1;
            cntNext   = cnt - 1'b1;
          end else begin
            validNext = 1'b0;
            doneNext  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      oD_valid <= 1'b0;
      oR_done  <= 1'b0;
      oD_out   <= '0;
    end else begin
      state    <= stateNext;
      ptr      <= ptrNext;
      cnt      <= cntNext;
      oD_valid <= validNext;
      oR_done  <= doneNext;
      if (loadBeat)
        oD_out <= rdWord;
    end
  end

  assign oR_busy = (state == BURST);

endmodule
